// File: rtl/cic_interp.sv
// CIC interpolator: m combs at the input sample rate, zero-stuffing by r, then m integrators at the clock rate.
// Optional macro CIC_INTERP_ROUND_EN: round half up with positive saturation instead of plain truncation.
module cic_interp #(
  parameter int idw = 16,
  parameter int odw = 16,
  parameter int r   = 128,
  parameter int m   = 2,
  parameter int g   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [idw-1:0]   data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [odw-1:0]   data_out,
  output logic             out_dv,
  output logic             underrun
);
  // state | meaning
  // IDLE  | waiting for the first sample, phase held at 0, integrators held at 0
  // RUN   | phase counts 0..r-1, slot at phase 0, integrators run every cycle

  localparam int bw  = idw + $clog2((r * g) ** m / r);
  localparam int cw  = idw + m;
  localparam int pw  = (r > 2) ? $clog2(r) : 1;
  localparam int dvw = $clog2(m + 1);
  localparam int sh  = bw - odw;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [pw-1:0]          phase;
  logic [dvw-1:0]         dv_cnt;
  logic                   accept;
  logic                   slot;
  logic signed [idw-1:0]  sample;
  logic signed [cw-1:0]   comb_last;
  logic signed [cw-1:0]   comb_q;
  logic signed [bw-1:0]   comb_ext;
  logic signed [bw-1:0]   up;
  logic signed [bw-1:0]   integ [m];
  logic signed [bw-1:0]   integ_last;
  logic [odw-1:0]         out_next;

  assign in_ready = (state == IDLE) || (phase == '0);
  assign accept   = in_valid && in_ready;
  assign slot     = accept || ((state == RUN) && (phase == '0));
  // A slot with no valid input injects a zero sample.
  assign sample   = in_valid ? $signed(data_in) : '0;
  assign underrun = (state == RUN) && (phase == '0) && !in_valid;

  for (genvar j = 0; j < m; j++) begin : g_comb
    localparam int sw = idw + j + 1;
    logic signed [sw-1:0] x;
    logic signed [sw-1:0] y;
    logic signed [sw-1:0] dly [g];

    if (j == 0) begin : g_first
      assign x = sw'(sample);
    end else begin : g_next
      assign x = sw'(g_comb[j-1].y);
    end

    assign y = x - dly[g-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < g; k++) dly[k] <= '0;
      end else if (slot) begin
        dly[0] <= x;
        for (int k = 1; k < g; k++) dly[k] <= dly[k-1];
      end
    end
  end

  assign comb_last = g_comb[m-1].y;
  assign comb_ext  = bw'(comb_q);
  // The comb result enters the integrators exactly once per period, on the cycle after the slot.
  assign up        = ((state == RUN) && (phase == pw'(1))) ? comb_ext : '0;
  assign integ_last = integ[m-1];

`ifdef CIC_INTERP_ROUND_EN
  if (sh == 0) begin : g_pass
    assign out_next = integ_last;
  end else begin : g_round
    localparam int half = 1 << (sh - 1);
    logic signed [bw:0]  rsum;
    logic signed [odw:0] rq;
    assign rsum = {integ_last[bw-1], integ_last} + (bw+1)'(half);
    assign rq   = (odw+1)'(rsum >>> sh);
    // Rounding only moves upward, so only positive overflow is possible.
    assign out_next = (!rq[odw] && rq[odw-1]) ? {1'b0, {(odw-1){1'b1}}} : rq[odw-1:0];
  end
`else
  assign out_next = odw'(integ_last >>> sh);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      dv_cnt   <= '0;
      out_dv   <= 1'b0;
      comb_q   <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= RUN;
            phase  <= pw'(1);
            dv_cnt <= dvw'(m);
          end
        end
        RUN: begin
          phase <= (phase == pw'(r - 1)) ? '0 : phase + pw'(1);
          if (dv_cnt != '0) dv_cnt <= dv_cnt - dvw'(1);
          else              out_dv <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (slot) comb_q <= comb_last;
      data_out <= out_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (state == IDLE)) begin
      for (int k = 0; k < m; k++) integ[k] <= '0;
    end else begin
      integ[0] <= integ[0] + up;
      for (int k = 1; k < m; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp (m=2, r=4, g=1, idw=8, odw=10): random and directed stimulus vs a convolution model.
module tb_cic_interp;
  localparam int IDW = 8;
  localparam int ODW = 10;
  localparam int R   = 4;
  localparam int M   = 2;
  localparam int G   = 1;
  localparam int BW  = IDW + $clog2((R * G) ** M / R);

  logic           clk;
  logic           reset;
  logic [IDW-1:0] data_in;
  logic           in_valid;
  logic           in_ready;
  logic [ODW-1:0] data_out;
  logic           out_dv;
  logic           underrun;

  int errors = 0;
  int checks = 0;

  int stim_q[$];
  bit vld_q[$];
  int exp_q[$];
  int dout_q[$];
  bit dv_q[$];
  bit rdy_q[$];
  bit und_q[$];
  bit hold_valid;

  cic_interp #(.idw(IDW), .odw(ODW), .r(R), .m(M), .g(G)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .out_dv   (out_dv),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output of the whole filter = zero-stuffed input convolved with (boxcar of length r*g)^m,
  // wrapped to bw bits, then truncated to odw bits.
  function automatic void build_model(input int ns);
    longint h[$];
    longint t[$];
    longint acc;
    longint w;
    longint mask;
    int d;
    h.delete();
    h.push_back(1);
    for (int i = 0; i < M; i++) begin
      t.delete();
      for (int n = 0; n < h.size() + R * G - 1; n++) begin
        acc = 0;
        for (int k = 0; k < R * G; k++)
          if (n - k >= 0 && n - k < h.size()) acc += h[n-k];
        t.push_back(acc);
      end
      h = t;
    end
    mask = (longint'(1) << BW) - 1;
    exp_q.delete();
    for (int n = 0; n < ns * R; n++) begin
      acc = 0;
      for (int s = 0; s < ns; s++) begin
        d = n - s * R;
        if (vld_q[s] && d >= 0 && d < h.size()) acc += longint'(stim_q[s]) * h[d];
      end
      w = acc & mask;
      if (w >= (longint'(1) << (BW - 1))) w -= (longint'(1) << BW);
      exp_q.push_back(int'(w >>> (BW - ODW)));
    end
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    data_in  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives ns slots starting from IDLE; records per-cycle observations. Cycle 0 is the first accept.
  task automatic drive(input int ns);
    dout_q.delete(); dv_q.delete(); rdy_q.delete(); und_q.delete();
    for (int c = 0; c < ns * R; c++) begin
      if (c % R == 0) begin
        in_valid = vld_q[c / R];
        data_in  = IDW'(stim_q[c / R]);
      end else begin
        in_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
        data_in  = IDW'($urandom);
      end
      #1;
      rdy_q.push_back(in_ready);
      und_q.push_back(underrun);
      @(negedge clk);
      dout_q.push_back(int'($signed(data_out)));
      dv_q.push_back(out_dv);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1 || out_dv !== 1'b0 || underrun !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_values rdy=%b dv=%b und=%b out=%0d required 1 0 0 0", in_ready, out_dv, underrun, data_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_dv !== 1'b0 || underrun !== 1'b0 || data_out !== '0) begin
        errors++;
        $display("FAIL idle_wait i=%0d rdy=%b dv=%b und=%b out=%0d required 1 0 0 0", i, in_ready, out_dv, underrun, data_out);
      end
    end
  endtask

  task automatic test_impulse();
    int seq[8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    int e;
    int sum;
    do_reset();
    stim_q = '{1, 0, 0, 0};
    vld_q  = '{1, 1, 1, 1};
    hold_valid = 1'b1;
    build_model(4);
    drive(4);
    sum = 0;
    for (int c = 0; c < 4 * R; c++) begin
      e = (c >= 1 + M) ? exp_q[c-1-M] : 0;
      sum += dout_q[c];
      checks++;
      if (dout_q[c] !== e) begin
        errors++;
        $display("FAIL impulse_out c=%0d got %0d required %0d", c, dout_q[c], e);
      end
      checks++;
      if (dv_q[c] !== (c >= 1 + M)) begin
        errors++;
        $display("FAIL impulse_dv c=%0d got %b required %b", c, dv_q[c], (c >= 1 + M));
      end
      checks++;
      if (rdy_q[c] !== (c % R == 0)) begin
        errors++;
        $display("FAIL impulse_ready c=%0d got %b required %b", c, rdy_q[c], (c % R == 0));
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout_q[3+i] !== seq[i]) begin
        errors++;
        $display("FAIL impulse_seq i=%0d got %0d required %0d", i, dout_q[3+i], seq[i]);
      end
    end
    checks++;
    if (sum !== 16) begin
      errors++;
      $display("FAIL impulse_sum got %0d required 16", sum);
    end
  endtask

  task automatic test_dc();
    int lvl[3]  = '{1, -1, -128};
    int fin[3]  = '{4, -4, -512};
    int e;
    for (int l = 0; l < 3; l++) begin
      do_reset();
      stim_q.delete(); vld_q.delete();
      for (int s = 0; s < 5; s++) begin
        stim_q.push_back(lvl[l]);
        vld_q.push_back(1'b1);
      end
      hold_valid = 1'b1;
      build_model(5);
      drive(5);
      for (int c = 0; c < 5 * R; c++) begin
        e = (c >= 1 + M) ? exp_q[c-1-M] : 0;
        checks++;
        if (dout_q[c] !== e) begin
          errors++;
          $display("FAIL dc_out lvl=%0d c=%0d got %0d required %0d", lvl[l], c, dout_q[c], e);
        end
        if (lvl[l] < 0) begin
          checks++;
          if (dout_q[c] > 0) begin
            errors++;
            $display("FAIL dc_sign lvl=%0d c=%0d got %0d required <=0", lvl[l], c, dout_q[c]);
          end
        end
      end
      checks++;
      if (dout_q[5*R-1] !== fin[l]) begin
        errors++;
        $display("FAIL dc_final lvl=%0d got %0d required %0d", lvl[l], dout_q[5*R-1], fin[l]);
      end
    end
  endtask

  task automatic test_underrun_random();
    int ns = 12;
    int e;
    int drops;
    int pulses;
    do_reset();
    stim_q.delete(); vld_q.delete();
    drops = 0;
    for (int s = 0; s < ns; s++) begin
      stim_q.push_back(int'($signed(IDW'($urandom))));
      vld_q.push_back((s == 0) ? 1'b1 : (s == 3) ? 1'b0 : ($urandom_range(0, 3) != 0));
      if (!vld_q[s]) drops++;
    end
    hold_valid = 1'b0;
    build_model(ns);
    drive(ns);
    pulses = 0;
    for (int c = 0; c < ns * R; c++) begin
      e = (c >= 1 + M) ? exp_q[c-1-M] : 0;
      if (und_q[c]) pulses++;
      checks++;
      if (dout_q[c] !== e) begin
        errors++;
        $display("FAIL random_out c=%0d got %0d required %0d", c, dout_q[c], e);
      end
      checks++;
      if (rdy_q[c] !== (c % R == 0)) begin
        errors++;
        $display("FAIL random_ready c=%0d got %b required %b", c, rdy_q[c], (c % R == 0));
      end
      checks++;
      if (und_q[c] !== (c % R == 0 && c != 0 && !vld_q[c / R])) begin
        errors++;
        $display("FAIL random_underrun c=%0d got %b required %b", c, und_q[c], (c % R == 0 && c != 0 && !vld_q[c / R]));
      end
      checks++;
      if (dv_q[c] !== (c >= 1 + M)) begin
        errors++;
        $display("FAIL random_dv c=%0d got %b required %b", c, dv_q[c], (c >= 1 + M));
      end
    end
    checks++;
    if (pulses !== drops) begin
      errors++;
      $display("FAIL underrun_count got %0d required %0d", pulses, drops);
    end
  endtask

  task automatic test_reset_mid_period();
    int e;
    do_reset();
    stim_q = '{1};
    vld_q  = '{1};
    hold_valid = 1'b1;
    drive(1);
    in_valid = 1'b1;
    data_in  = '0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (int'($signed(data_out)) !== 3) begin
      errors++;
      $display("FAIL midreset_pre out got %0d required 3", $signed(data_out));
    end
    reset    = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'd5;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_dv !== 1'b0 || underrun !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL midreset_values rdy=%b dv=%b und=%b out=%0d required 1 0 0 0", in_ready, out_dv, underrun, data_out);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2 + M; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_dv !== 1'b0 || data_out !== '0) begin
        errors++;
        $display("FAIL midreset_idle i=%0d rdy=%b dv=%b out=%0d required 1 0 0", i, in_ready, out_dv, data_out);
      end
    end
    stim_q = '{1, 0, 0, 0};
    vld_q  = '{1, 1, 1, 1};
    build_model(4);
    drive(4);
    for (int c = 0; c < 4 * R; c++) begin
      e = (c >= 1 + M) ? exp_q[c-1-M] : 0;
      checks++;
      if (dout_q[c] !== e) begin
        errors++;
        $display("FAIL midreset_restart c=%0d got %0d required %0d", c, dout_q[c], e);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    data_in    = '0;
    hold_valid = 1'b1;
    @(negedge clk);
    test_reset();
    test_impulse();
    test_dc();
    test_underrun_random();
    test_reset_mid_period();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cic_interp.md
# cic_interp

CIC interpolation filter, the transmit-direction counterpart of the decimating CIC chain. It accepts one low-rate sample every `r` clocks through a valid/ready handshake and runs `m` comb stages at the input rate. A zero-stuffing upsampler follows, then `m` integrator stages at the clock rate, producing one output sample per clock. It feeds the high-rate side of the array datapath, for example a PDM modulator or DAC driver.

## Interface
Parameters:
- `idw`, 16: input data width, signed.
- `odw`, 16: output data width, signed. `odw` must not exceed `bw`.
- `r`, 128: interpolation ratio, at least 2.
- `m`, 2: CIC order, the number of combs and the number of integrators.
- `g`, 1: differential delay in the combs, 1 or 2.
- Derived, not overridable: `bw` = idw + $clog2((r*g)**m / r), the integrator width.

Ports:
- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `data_in`, in, idw: signed input sample.
- `in_valid`, in, 1: `data_in` is valid.
- `in_ready`, out, 1: the block accepts `data_in` this cycle.
- `data_out`, out, odw: signed output sample.
- `out_dv`, out, 1: `data_out` is valid. Once it rises it stays high every cycle until reset.
- `underrun`, out, 1: one-cycle pulse when a sample slot passed with no input available.

## Operation
- **FSM states:**
  - `IDLE`: entered on reset. `in_ready`=1 and the phase counter is held at 0. An accept (`in_valid` && `in_ready`) moves to `RUN`.
  - `RUN`: the phase counter counts 0..r-1 and wraps. `in_ready`=1 only when phase==0. No exit except reset.
- **Sample slot (phase==0 in RUN, or the accept cycle in IDLE):**
  - If `in_valid`=1, the sample is accepted.
  - If `in_valid`=0 in RUN, a zero sample is injected instead and `underrun` pulses in that same cycle.
- **Comb chain:**
  - Stage j (1..m) has width idw+j, a sign-extended input, and y = x − x delayed by `g` slots.
  - Delay registers update only on slot cycles.
  - The comb output register loads on the slot cycle.
- **Upsampler:**
  - Presents the comb output register on the cycle after the slot.
  - Presents zero on the other r−1 cycles of the period.
  - Sign-extends to `bw`.
- **Integrators:**
  - m registered stages, all `bw` wide.
  - Two's-complement wrap-around is required; no saturation inside the chain.
  - They update every cycle in RUN and hold 0 in IDLE.
- **Output:** `data_out` = integrator m bits [bw-1 : bw-odw] (truncation), except as changed by the macro under Configuration.
- **DC gain:** (r*g)^m / r.
- **Reset:** `reset` in any state, including mid-period, does the following on the next edge:
  - Returns the FSM to `IDLE` and clears all comb, delay, integrator and phase registers.
  - Drives `data_out`=0, `out_dv`=0, `underrun`=0 and `in_ready`=1.

## Timing
- **Reset values:** `data_out`=0, `out_dv`=0, `underrun`=0, `in_ready`=1.
- **Latency:** a sample accepted at edge t first affects `data_out` at edge t+1+m.
- **`out_dv`:** rises at edge t+1+m after the first accept.
- **Input rate:** exactly one accept per r cycles in RUN. `in_valid` held high continuously yields one accept every r clocks.
- **Simultaneous events:** when `reset` and `in_valid` are both high, reset wins and the sample is not accepted.
- **Wrap-around:** the phase counter goes r−1 → 0 with no idle cycle.

## Configuration
- Macro `CIC_INTERP_ROUND_EN`.
- **Defined:**
  - The output adds 2^(bw−odw−1) to integrator m before truncation (round half up).
  - On positive overflow it saturates to 2^(odw−1)−1.
  - When odw==bw, no rounding is applied.
  - Latency is unchanged; the rounding is combinational into the `data_out` register.
- **Undefined:** plain truncation as described under Operation.

## Test plan
- **Impulse:** m=2, r=4, g=1, idw=8, odw=10 (bw=10). Send one sample of 1, then zeros with `in_valid` held high. `data_out` from edge t+3 must read 1,2,3,4,3,2,1,0,0…, summing to 16.
- **DC step:** same configuration, constant input 1. `data_out` must read 1,2,3,4, then hold 4; −1 must hold −4.
- **Full scale:** same configuration, constant input −128. Output must settle to −512 without the wrong-sign glitch that would indicate wrap misuse.
- **Handshake and underrun:**
  - `in_ready` must assert only every 4th cycle in RUN.
  - Drop `in_valid` at one slot: `underrun` must pulse once in that cycle, and the output must match the zero-injected reference model.
- **Reset mid-period:** assert `reset` at phase 2 while the output is nonzero. Next edge: all outputs at reset values and FSM in IDLE. The next accept restarts the impulse response exactly.
- **Rounding (macro defined):** bw=10, odw=8, integrator value 6 → `data_out`=2 (truncation gives 1). Value 510 → saturate to 127.
